// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point multiplier: rounding modes,
// FSM state encoding and width-parametrised special-value constants.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RND  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    localparam int FP_MAX_W = 64;
    localparam logic [FP_MAX_W-1:0] FP_ONE = 1;

    function automatic logic [FP_MAX_W-1:0] ones(input int n);
        return (FP_ONE << n) - FP_ONE;
    endfunction

    // Callers slice the low 1+exp_w+frc_w bits; the sign bit is always zero.
    function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int frc_w);
        return (ones(exp_w) << frc_w) | (FP_ONE << (frc_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] max_finite(input int exp_w, input int frc_w);
        return ((ones(exp_w) - FP_ONE) << frc_w) | ones(frc_w);
    endfunction

    function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic rbit, input logic sticky);
        logic inexact;
        inexact  = guard | rbit | sticky;
        round_up = guard & (rbit | sticky | lsb);
        case (mode)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & sign;
            RM_RUP:  round_up = inexact & ~sign;
            RM_RMM:  round_up = guard;
            default: ;
        endcase
    endfunction

endpackage

// File: rtl/fp_mul_iter_if.sv
// Operand/result handshake bundle for fp_mul_iter; master drives operands, slave is the multiplier.
interface fp_mul_iter_if #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
);
    localparam int W = 1 + EXP_W + FRC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fp_X;
    logic [W-1:0] fp_Y;
    logic [2:0]   r_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fp_Z;
    logic         ovrf;
    logic         udrf;

    modport master (
        output in_valid, fp_X, fp_Y, r_mode, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, r_mode, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf
    );
endinterface

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: recode two multiplier bits, add the partial product to the
// accumulator, then arithmetic-shift the {acc, multiplier, q_m1} chain right by two.
module booth_r4_step #(
    parameter int N  = 24,
    parameter int AW = N + 3,
    parameter int QW = 26
) (
    input  logic [N-1:0]  mcand,
    input  logic [AW-1:0] acc,
    input  logic [QW-1:0] mq,
    input  logic          q_m1,
    output logic [AW-1:0] acc_nxt,
    output logic [QW-1:0] mq_nxt,
    output logic          q_m1_nxt
);
    logic [AW-1:0] m_ext;
    logic [AW-1:0] pp;
    logic [AW-1:0] sum;

    assign m_ext = AW'(mcand);

    always_comb begin
        pp = '0;
        case ({mq[1:0], q_m1})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end

    assign sum      = acc + pp;
    assign acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign mq_nxt   = {sum[1:0], mq[QW-1:2]};
    assign q_m1_nxt = mq[1];
endmodule

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-style multiplier: Booth radix-4 significand product over ITER cycles, then a
// single normalise/round cycle. Special operands (NaN/inf/zero/subnormal) bypass straight to DONE.
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input logic          clk,
    input logic          rst,
    fp_mul_iter_if.slave bus
);
    import fp_pkg::*;

    localparam int W    = 1 + EXP_W + FRC_W;
    localparam int N    = FRC_W + 1;
    localparam int ITER = (FRC_W + 3) / 2;
    localparam int QW   = 2 * ITER;
    localparam int AW   = N + 3;
    localparam int PW   = 2 * N;
    localparam int CW   = $clog2(ITER + 1);
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_RND  = ST_RND;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [FP_MAX_W-1:0] NAN_FULL = canon_nan(EXP_W, FRC_W);
    localparam logic [FP_MAX_W-1:0] MAX_FULL = max_finite(EXP_W, FRC_W);
    localparam logic [W-1:0]        QNAN     = NAN_FULL[W-1:0];
    localparam logic [W-2:0]        MAX_MAG  = MAX_FULL[W-2:0];
    localparam logic [W-2:0]        INF_MAG  = {{EXP_W{1'b1}}, {FRC_W{1'b0}}};
    localparam logic [EW-1:0]       EXP_ONES = {2'b00, {EXP_W{1'b1}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic [EXP_W-1:0] ex_q;
    logic [EXP_W-1:0] ey_q;
    logic [FRC_W-1:0] fx_q;
    logic [2:0]       mode_q;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_nxt;
    logic [QW-1:0]    mq;
    logic [QW-1:0]    mq_nxt;
    logic             q_m1;
    logic             q_m1_nxt;
    logic [W-1:0]     z_q;
    logic             ovrf_q;
    logic             udrf_q;

    logic [EXP_W-1:0] in_ex;
    logic [EXP_W-1:0] in_ey;
    logic [FRC_W-1:0] in_fx;
    logic [FRC_W-1:0] in_fy;
    logic             in_sign;
    logic             x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic             special;
    logic [W-1:0]     special_z;

    // Subnormals count as zero here, so inf times a subnormal also yields the canonical NaN.
    always_comb begin
        in_ex     = bus.fp_X[W-2 -: EXP_W];
        in_ey     = bus.fp_Y[W-2 -: EXP_W];
        in_fx     = bus.fp_X[FRC_W-1:0];
        in_fy     = bus.fp_Y[FRC_W-1:0];
        in_sign   = bus.fp_X[W-1] ^ bus.fp_Y[W-1];
        x_nan     = (&in_ex) & (|in_fx);
        y_nan     = (&in_ey) & (|in_fy);
        x_inf     = (&in_ex) & ~(|in_fx);
        y_inf     = (&in_ey) & ~(|in_fy);
        x_zero    = ~(|in_ex);
        y_zero    = ~(|in_ey);
        special   = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
        special_z = {in_sign, {(W-1){1'b0}}};
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            special_z = QNAN;
        end else if (x_inf || y_inf) begin
            special_z = {in_sign, INF_MAG};
        end
    end

    booth_r4_step #(
        .N  (N),
        .AW (AW),
        .QW (QW)
    ) u_step (
        .mcand    ({1'b1, fx_q}),
        .acc      (acc),
        .mq       (mq),
        .q_m1     (q_m1),
        .acc_nxt  (acc_nxt),
        .mq_nxt   (mq_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    logic [AW+QW-1:0] full;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    norm;
    logic [FRC_W-1:0] frac;
    logic [FRC_W:0]   frac_sum;
    logic             guard, rbit, sticky, inc, carry;
    logic [EW-1:0]    exp_fin;
    logic             ovf, udf;
    logic [W-2:0]     ovf_mag;
    logic [W-1:0]     rnd_z;
    logic             unused_bits;

    // The exponent is computed two bits wider than stored so that overflow and the
    // negative (underflow) range are both visible after the bias subtraction.
    always_comb begin
        full     = {acc, mq};
        prod     = full[PW-1:0];
        norm     = prod[PW-1] ? prod : (prod << 1);
        frac     = norm[PW-2 -: FRC_W];
        guard    = norm[N-1];
        rbit     = norm[N-2];
        sticky   = |norm[N-3:0];
        inc      = round_up(mode_q, sign_q, frac[0], guard, rbit, sticky);
        frac_sum = {1'b0, frac} + {{FRC_W{1'b0}}, inc};
        carry    = frac_sum[FRC_W];
        exp_fin  = EW'(ex_q) + EW'(ey_q) + EW'(prod[PW-1]) + EW'(carry) - EW'(BIAS);
        ovf      = !exp_fin[EW-1] && (exp_fin >= EXP_ONES);
        udf      = exp_fin[EW-1] || (exp_fin == '0);
        ovf_mag  = INF_MAG;
        if ((mode_q == RM_RTZ) || (mode_q == RM_RDN && !sign_q) || (mode_q == RM_RUP && sign_q)) begin
            ovf_mag = MAX_MAG;
        end
        if (ovf) begin
            rnd_z = {sign_q, ovf_mag};
        end else if (udf) begin
            rnd_z = {sign_q, {(W-1){1'b0}}};
        end else begin
            rnd_z = {sign_q, exp_fin[EXP_W-1:0], frac_sum[FRC_W-1:0]};
        end
    end

    assign unused_bits = ^{full[AW+QW-1:PW], norm[PW-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sign_q <= 1'b0;
            ex_q   <= '0;
            ey_q   <= '0;
            fx_q   <= '0;
            mode_q <= '0;
            acc    <= '0;
            mq     <= '0;
            q_m1   <= 1'b0;
            z_q    <= '0;
            ovrf_q <= 1'b0;
            udrf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (special) begin
                            state  <= S_DONE;
                            z_q    <= special_z;
                            ovrf_q <= 1'b0;
                            udrf_q <= 1'b0;
                        end else begin
                            state  <= S_MUL;
                            sign_q <= in_sign;
                            ex_q   <= in_ex;
                            ey_q   <= in_ey;
                            fx_q   <= in_fx;
                            mode_q <= bus.r_mode;
                            acc    <= '0;
                            mq     <= QW'({1'b1, in_fy});
                            q_m1   <= 1'b0;
                            cnt    <= '0;
                        end
                    end
                end
                S_MUL: begin
                    acc  <= acc_nxt;
                    mq   <= mq_nxt;
                    q_m1 <= q_m1_nxt;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= S_RND;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RND: begin
                    state  <= S_DONE;
                    z_q    <= rnd_z;
                    ovrf_q <= ovf;
                    udrf_q <= udf;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.fp_Z      = z_q;
    assign bus.ovrf      = ovrf_q;
    assign bus.udrf      = udrf_q;
endmodule
